// File: rtl/fdre_bank_arbiter.sv
// Round-robin write arbiter in front of a small preset-to-ones register bank, with a one-entry-per-cycle preset sweep.
// Optional grant counter output gnt_cnt is enabled by defining FDRE_BANK_ARB_GNTCNT_EN.
module fdre_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              C,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] wr_addr,
  input  logic [NREQ*W-1:0] wr_data,
  output logic [NREQ-1:0]   gnt,
  input  logic              sweep_start,
  output logic              busy,
  input  logic [AW-1:0]     rd_addr,
  output logic [W-1:0]      rd_data
`ifdef FDRE_BANK_ARB_GNTCNT_EN
  ,
  output logic [15:0]       gnt_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  logic [0:0]    state_reg;
  logic [PW-1:0] ptr_reg;
  logic [AW-1:0] sweep_idx_reg;
  logic          busy_reg;
  logic [W-1:0]  entry_reg [DEPTH];

  logic          win_valid;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] ptr_next;
  logic [AW-1:0] win_addr;
  logic [W-1:0]  win_data;
  logic          wr_en;
  logic          sweep_we;
  int            cand;

  // First requester at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr_reg) + k) % NREQ;
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = PW'(cand);
      end
    end
  end

  assign win_addr = wr_addr[win_idx*AW +: AW];
  assign win_data = wr_data[win_idx*W +: W];
  assign wr_en    = (state_reg == ST_IDLE) && win_valid;
  assign sweep_we = (state_reg == ST_SWEEP);
  assign ptr_next = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    gnt = '0;
    if (rst_n && wr_en) begin
      gnt[win_idx] = 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge C or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg[gi] <= '1;
        end else if (sweep_we && sweep_idx_reg == AW'(gi)) begin
          entry_reg[gi] <= '1;
        end else if (wr_en && win_addr == AW'(gi)) begin
          entry_reg[gi] <= win_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge C or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= '0;
      sweep_idx_reg <= '0;
      busy_reg      <= 1'b0;
    end else begin
      if (wr_en) begin
        ptr_reg <= ptr_next;
      end
      if (state_reg == ST_IDLE) begin
        if (sweep_start) begin
          state_reg     <= ST_SWEEP;
          sweep_idx_reg <= '0;
          busy_reg      <= 1'b1;
        end
      end else begin
        sweep_idx_reg <= sweep_idx_reg + 1'b1;
        if (sweep_idx_reg == AW'(DEPTH-1)) begin
          state_reg     <= ST_IDLE;
          sweep_idx_reg <= '0;
          busy_reg      <= 1'b0;
        end
      end
    end
  end

`ifdef FDRE_BANK_ARB_GNTCNT_EN
  always_ff @(posedge C or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt <= '0;
    end else if (wr_en && gnt_cnt != 16'hFFFF) begin
      gnt_cnt <= gnt_cnt + 16'd1;
    end
  end
`endif

  assign busy    = busy_reg;
  assign rd_data = entry_reg[rd_addr];

endmodule

// File: tb/tb_fdre_bank_arbiter.sv
// Directed self-checking bench for fdre_bank_arbiter (NREQ=4, W=8, DEPTH=4).
module tb_fdre_bank_arbiter;

  logic        C;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  gnt;
  logic        sweep_start;
  logic        busy;
  logic [1:0]  rd_addr;
  logic [7:0]  rd_data;
`ifdef FDRE_BANK_ARB_GNTCNT_EN
  logic [15:0] gnt_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fdre_bank_arbiter #(.NREQ(4), .W(8), .DEPTH(4)) dut (
    .C           (C),
    .rst_n       (rst_n),
    .req         (req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .gnt         (gnt),
    .sweep_start (sweep_start),
    .busy        (busy),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
`ifdef FDRE_BANK_ARB_GNTCNT_EN
    ,
    .gnt_cnt     (gnt_cnt)
`endif
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", tag, obs, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic check_read(input string tag, input logic [1:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    check(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  initial begin
    rst_n       = 1'b0;
    req         = 4'b1111;
    wr_addr     = {2'd3, 2'd2, 2'd1, 2'd0};
    wr_data     = {8'h13, 8'h12, 8'h11, 8'h10};
    sweep_start = 1'b0;
    rd_addr     = 2'd0;
    #1;
    check("gnt_in_reset", {28'd0, gnt}, 32'h0);
    tick();
    tick();
    req = 4'b0000;
    rst_n = 1'b1;
    #1;
    check("busy_after_reset", {31'd0, busy}, 32'h0);
    check("gnt_after_reset", {28'd0, gnt}, 32'h0);
    for (int a = 0; a < 4; a++) check_read($sformatf("reset_rd%0d", a), 2'(a), 8'hFF);

    // Four requesters, round robin from pointer 0.
    req = 4'b1111;
    rd_addr = 2'd0;
    #1;
    check("rd0_pre_edge", {24'd0, rd_data}, 32'hFF);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr_gnt%0d", i), {28'd0, gnt}, 32'(1 << i));
      tick();
      req[i] = 1'b0;
    end
    for (int a = 0; a < 4; a++) check_read($sformatf("rr_rd%0d", a), 2'(a), 8'(8'h10 + a));

    // Move the pointer to 2, then contend 0 and 1.
    req = 4'b0010;
    #1;
    check("ptr_set_gnt", {28'd0, gnt}, 32'h2);
    tick();
    req = 4'b0011;
    #1;
    check("wrap_gnt0", {28'd0, gnt}, 32'h1);
    tick();
    req = 4'b0010;
    #1;
    check("wrap_gnt1", {28'd0, gnt}, 32'h2);
    tick();
    req = 4'b1000;
    #1;
    check("lone_gnt3", {28'd0, gnt}, 32'h8);
    tick();

    // Sweep launched in the same cycle as a req[1] write.
    req = 4'b0010;
    wr_data[15:8] = 8'h55;
    sweep_start = 1'b1;
    #1;
    check("sweep_cycle_gnt", {28'd0, gnt}, 32'h2);
    tick();
    sweep_start = 1'b0;
    check_read("sweep_commit_rd1", 2'd1, 8'h55);
    for (int s = 0; s < 4; s++) begin
      sweep_start = (s == 1);
      #1;
      check($sformatf("sweep_busy%0d", s), {31'd0, busy}, 32'h1);
      check($sformatf("sweep_gnt%0d", s), {28'd0, gnt}, 32'h0);
      tick();
    end
    sweep_start = 1'b0;
    check("busy_end", {31'd0, busy}, 32'h0);
    for (int a = 0; a < 4; a++) check_read($sformatf("swept_rd%0d", a), 2'(a), 8'hFF);
    check("held_req1_gnt", {28'd0, gnt}, 32'h2);
    tick();
    req = 4'b0000;
    check_read("post_sweep_rd1", 2'd1, 8'h55);

    // Pointer is 2; write via requester 0, leaving pointer 1.
    req = 4'b0001;
    #1;
    check("pre_reset_gnt0", {28'd0, gnt}, 32'h1);
    tick();
    req = 4'b0000;
`ifdef FDRE_BANK_ARB_GNTCNT_EN
    check("gnt_cnt_total", {16'd0, gnt_cnt}, 32'd11);
`endif
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    check("midsweep_busy1", {31'd0, busy}, 32'h1);
    tick();
    check_read("midsweep_rd1_unswept", 2'd1, 8'h55);
    rst_n = 1'b0;
    #1;
    check("midsweep_reset_busy", {31'd0, busy}, 32'h0);
    check_read("midsweep_reset_rd1", 2'd1, 8'hFF);
    check_read("midsweep_reset_rd2", 2'd2, 8'hFF);
    rst_n = 1'b1;
`ifdef FDRE_BANK_ARB_GNTCNT_EN
    #1;
    check("gnt_cnt_reset", {16'd0, gnt_cnt}, 32'd0);
`endif
    req = 4'b1111;
    #1;
    check("post_reset_gnt", {28'd0, gnt}, 32'h1);
    tick();
    check("post_reset_busy", {31'd0, busy}, 32'h0);
    check("post_reset_next_gnt", {28'd0, gnt}, 32'h2);
    check_read("post_reset_rd0", 2'd0, 8'h10);
`ifdef FDRE_BANK_ARB_GNTCNT_EN
    check("gnt_cnt_one", {16'd0, gnt_cnt}, 32'd1);
`endif
    req = 4'b0000;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fdre_bank_arbiter.md
Name: fdre_bank_arbiter

Overview:
- Round-robin arbiter that shares a small bank of preset-to-ones registers between NREQ write requesters.
- Includes a sweep sequencer that re-presets every bank entry to all-ones, one entry per cycle.
- Sits between the requester logic and the preset-flop storage; it alone decides which requester writes, and when the bank is swept back to its preset state.

Parameters:
- NREQ, 4, number of requesters (>=2).
- W, 8, data width of each bank entry.
- DEPTH, 4, number of bank entries (power of two, >=2); AW = $clog2(DEPTH) is derived.

Ports:
- C  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester write request, level.
- wr_addr  input  NREQ*AW  requester i's address in bits [i*AW +: AW].
- wr_data  input  NREQ*W  requester i's data in bits [i*W +: W].
- gnt  output  NREQ  one-hot grant, combinational; write commits at the next rising edge of C.
- sweep_start  input  1  single-cycle pulse requesting a preset sweep.
- busy  output  1  high while the sweep is in progress.
- rd_addr  input  AW  read address.
- rd_data  output  W  combinational read of entry[rd_addr].

Behaviour:
- Reset (rst_n low, asynchronous):
  - all entries = {W{1'b1}}; rr pointer = 0; state = IDLE; sweep index = 0; busy = 0.
  - gnt is forced to 0 while rst_n is low.
- States: IDLE, SWEEP. busy is registered and equals (state == SWEEP).
- IDLE arbitration:
  - Winner = first i, searching from pointer upward with wrap modulo NREQ, with req[i] = 1.
  - gnt is one-hot on the winner, or 0 if no req is high.
- IDLE commit: at the rising edge, entry[wr_addr of winner] <= wr_data of winner, and pointer <= (winner + 1) mod NREQ.
- No request: pointer and bank unchanged.
- Grant latency: grant is same-cycle (combinational); data is visible on rd_data the cycle after the grant.
- Requesters hold req until they see gnt. A requester whose req is low when it would have won simply loses its turn; there is no stored pending state.
- IDLE with sweep_start = 1:
  - that cycle's grant and write still happen;
  - next state = SWEEP, sweep index = 0.
- SWEEP:
  - gnt = 0 regardless of req; pointer frozen.
  - Each cycle: entry[sweep index] <= all-ones, then index++.
  - The cycle that writes index DEPTH-1 is the last SWEEP cycle; the next state is IDLE.
  - busy is high for exactly DEPTH cycles, starting the cycle after the sweep_start pulse.
- sweep_start while in SWEEP is ignored; it is not queued.
- Sweep writes use no arbitration; requests made during SWEEP are served after returning to IDLE, starting from the frozen pointer.
- Read: rd_data = entry[rd_addr] combinationally, and shows the pre-edge value in the cycle of a write.
- Reset mid-sweep: the bank returns to all-ones immediately and state = IDLE; the partially swept index is discarded.
- Address wrap: wr_addr and rd_addr are exactly AW bits, so there are no out-of-range entries.

Optional Feature:
- Macro: FDRE_BANK_ARB_GNTCNT_EN.
- Defined: adds output gnt_cnt [15:0]:
  - reset value 0;
  - increments by 1 on every edge that commits a granted write;
  - saturates at 16'hFFFF;
  - unaffected by sweeps.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, no activity -> rd_data = 8'hFF for rd_addr 0..3; gnt = 0; busy = 0.
- req = 4'b1111, each requester i writes addr i, data 8'h10+i, held until granted:
  - gnt sequence is 0001, 0010, 0100, 1000 over four cycles;
  - the entries then read 10, 11, 12, 13.
- After pointer = 2, req = 4'b0011 -> gnt = 0001 then 0010; a following lone req[3] gets gnt = 1000 the next cycle.
- sweep_start pulse with req[1] active in the same cycle:
  - the req[1] write commits;
  - busy is high for exactly 4 cycles with gnt = 0 throughout;
  - all entries then read 8'hFF;
  - the held req[1] is granted in the first IDLE cycle.
- rst_n pulsed low during the 2nd SWEEP cycle -> all entries immediately read 8'hFF, busy = 0, and the next grant starts from requester 0.
- With FDRE_BANK_ARB_GNTCNT_EN defined:
  - 5 granted writes, then a sweep -> gnt_cnt = 5;
  - a forced-long run -> gnt_cnt saturates at 16'hFFFF.
